// File: rtl/regbank_alu_sequencer.sv
// Register file plus ALU execute engine with a start/busy/done handshake.
// Each accepted op reads two sources, executes, writes back and then streams
// the DATA_W-bit result as OUT_W-bit chunks, low chunk first, on a narrow bus.
// R0 is hardwired to zero; writes to it are dropped.
module regbank_alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int NREG   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              ALUfunc,
  input  logic [$clog2(NREG)-1:0] source1,
  input  logic [$clog2(NREG)-1:0] source2,
  input  logic [$clog2(NREG)-1:0] destination,
  input  logic [DATA_W-1:0]       imm,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        out,
  output logic                    out_valid,
  output logic [(((DATA_W/OUT_W) > 1) ? $clog2(DATA_W/OUT_W) : 1)-1:0] chunk_idx,
  output logic                    zero_flag,
  output logic                    carry_flag
);

  localparam int ADDR_W = $clog2(NREG);
  localparam int NCHUNK = DATA_W / OUT_W;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SH_W   = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_LDI  = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_SHOW  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t state_r;

  // Operands latched at start so the input ports may change during an op.
  logic [3:0]        func_r;
  logic [ADDR_W-1:0] src1_r;
  logic [ADDR_W-1:0] src2_r;
  logic [ADDR_W-1:0] dst_r;
  logic [DATA_W-1:0] imm_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] z_r;
  logic [CIDX_W-1:0] cnt_r;

  logic [DATA_W-1:0] regs_r [NREG];

  logic              busy_r;
  logic              done_r;
  logic [OUT_W-1:0]  out_r;
  logic              out_valid_r;
  logic [CIDX_W-1:0] chunk_idx_r;
  logic              zero_flag_r;
  logic              carry_flag_r;

  logic [DATA_W-1:0] alu_z_s;
  logic              alu_c_s;
  logic [DATA_W:0]   add_s;
  logic [SH_W-1:0]   sh_s;
  logic              last_chunk_s;

  // Register read with R0 forced to zero regardless of storage contents.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    if (idx == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else begin
      val = regs_r[idx];
    end
    return val;
  endfunction

  // Extract chunk k of a result word.
  function automatic logic [OUT_W-1:0] chunk_of(input logic [DATA_W-1:0] z, input int k);
    return z[k*OUT_W +: OUT_W];
  endfunction

  assign add_s        = {1'b0, a_r} + {1'b0, b_r};
  assign sh_s         = b_r[SH_W-1:0];
  assign last_chunk_s = (cnt_r == CIDX_W'(NCHUNK - 1));

  // ALU: combinational result and carry/borrow from the latched operands.
  always_comb begin
    alu_z_s = {DATA_W{1'b0}};
    alu_c_s = 1'b0;
    case (func_r)
      OP_ADD: begin
        alu_z_s = add_s[DATA_W-1:0];
        alu_c_s = add_s[DATA_W];
      end
      OP_SUB: begin
        alu_z_s = a_r - b_r;
        alu_c_s = (a_r < b_r);
      end
      OP_AND:  alu_z_s = a_r & b_r;
      OP_OR:   alu_z_s = a_r | b_r;
      OP_XOR:  alu_z_s = a_r ^ b_r;
      OP_NOT:  alu_z_s = ~a_r;
      OP_SLL:  alu_z_s = a_r << sh_s;
      OP_SRL:  alu_z_s = a_r >> sh_s;
      OP_SRA:  alu_z_s = $unsigned($signed(a_r) >>> sh_s);
      OP_MOV:  alu_z_s = a_r;
      OP_SLT:  alu_z_s[0] = ($signed(a_r) < $signed(b_r));
      OP_SLTU: alu_z_s[0] = (a_r < b_r);
      OP_LDI:  alu_z_s = imm_r;
      default: begin
        alu_z_s = {DATA_W{1'b0}};
        alu_c_s = 1'b0;
      end
    endcase
  end

  // Register file: cleared on reset, written once per op in the WRITE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_WRITE) && (dst_r != {ADDR_W{1'b0}})) begin
      regs_r[dst_r] <= z_r;
    end
  end

  // Sequencer FSM with registered handshake, display and flag outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      func_r       <= 4'd0;
      src1_r       <= {ADDR_W{1'b0}};
      src2_r       <= {ADDR_W{1'b0}};
      dst_r        <= {ADDR_W{1'b0}};
      imm_r        <= {DATA_W{1'b0}};
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      z_r          <= {DATA_W{1'b0}};
      cnt_r        <= {CIDX_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      out_r        <= {OUT_W{1'b0}};
      out_valid_r  <= 1'b0;
      chunk_idx_r  <= {CIDX_W{1'b0}};
      zero_flag_r  <= 1'b0;
      carry_flag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r      <= 1'b0;
          out_r       <= {OUT_W{1'b0}};
          out_valid_r <= 1'b0;
          chunk_idx_r <= {CIDX_W{1'b0}};
          if (start) begin
            func_r  <= ALUfunc;
            src1_r  <= source1;
            src2_r  <= source2;
            dst_r   <= destination;
            imm_r   <= imm;
            busy_r  <= 1'b1;
            state_r <= ST_READ;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          a_r     <= rd_reg(src1_r);
          b_r     <= rd_reg(src2_r);
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          z_r          <= alu_z_s;
          zero_flag_r  <= (alu_z_s == {DATA_W{1'b0}});
          carry_flag_r <= alu_c_s;
          state_r      <= ST_WRITE;
        end
        ST_WRITE: begin
          // Write-back happens in the register file block this same edge;
          // the first chunk is presented from here.
          cnt_r       <= {CIDX_W{1'b0}};
          out_r       <= chunk_of(z_r, 0);
          out_valid_r <= 1'b1;
          chunk_idx_r <= {CIDX_W{1'b0}};
          state_r     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (last_chunk_s) begin
            out_r       <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            chunk_idx_r <= {CIDX_W{1'b0}};
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r       <= cnt_r + CIDX_W'(1);
            out_r       <= chunk_of(z_r, int'(cnt_r) + 1);
            chunk_idx_r <= cnt_r + CIDX_W'(1);
            state_r     <= ST_SHOW;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          out_r       <= {OUT_W{1'b0}};
          out_valid_r <= 1'b0;
          chunk_idx_r <= {CIDX_W{1'b0}};
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign out        = out_r;
  assign out_valid  = out_valid_r;
  assign chunk_idx  = chunk_idx_r;
  assign zero_flag  = zero_flag_r;
  assign carry_flag = carry_flag_r;

endmodule

// File: tb/tb_regbank_alu_sequencer.sv
// Self-checking bench: a cycle-timeline model of the 32/16/16 instance checked
// every cycle, plus directed literal checks on it and on a 64/16/8 instance.
module tb_regbank_alu_sequencer;

  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_func = 4'd0;
  logic [3:0]  src1 = 4'd0, src2 = 4'd0, dst = 4'd0;
  logic [31:0] imm = 32'd0;
  logic        busy, done, out_valid, zero_flag, carry_flag;
  logic [15:0] out;
  logic [0:0]  chunk_idx;

  logic        start64 = 1'b0;
  logic [3:0]  func64 = 4'd0;
  logic [2:0]  s1_64 = 3'd0, s2_64 = 3'd0, d_64 = 3'd0;
  logic [63:0] imm64 = 64'd0;
  logic        busy64, done64, valid64, zf64, cf64;
  logic [15:0] out64;
  logic [1:0]  idx64;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regbank_alu_sequencer #(.DATA_W(32), .OUT_W(16), .NREG(16)) dut (
    .clk(clk), .reset(rst_n), .start(start), .ALUfunc(alu_func),
    .source1(src1), .source2(src2), .destination(dst), .imm(imm),
    .busy(busy), .done(done), .out(out), .out_valid(out_valid),
    .chunk_idx(chunk_idx), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  regbank_alu_sequencer #(.DATA_W(64), .OUT_W(16), .NREG(8)) dut64 (
    .clk(clk), .reset(rst_n), .start(start64), .ALUfunc(func64),
    .source1(s1_64), .source2(s2_64), .destination(d_64), .imm(imm64),
    .busy(busy64), .done(done64), .out(out64), .out_valid(valid64),
    .chunk_idx(idx64), .zero_flag(zf64), .carry_flag(cf64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (32-bit instance) ----------------
  // m_p counts clock edges since the op was accepted (0 = idle).
  logic [31:0] m_reg [16];
  int          m_p;
  logic [31:0] m_z;
  logic        m_zf, m_cf, m_zf_n, m_cf_n;

  function automatic logic [31:0] m_rd(input logic [3:0] i);
    return (i == 4'd0) ? 32'd0 : m_reg[i];
  endfunction

  // Returns {carry, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] iv);
    logic [4:0]         sh;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    case (f)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {(a < b), a - b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, ~a};
      4'd6:  return {1'b0, a << sh};
      4'd7:  return {1'b0, a >> sh};
      4'd8:  return {1'b0, 32'(sa >>> sh)};
      4'd9:  return {1'b0, a};
      4'd10: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
      4'd11: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'd12: return {1'b0, iv};
      default: return 33'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 32'd0;
      m_p <= 0; m_z <= 32'd0; m_zf <= 1'b0; m_cf <= 1'b0;
      m_zf_n <= 1'b0; m_cf_n <= 1'b0;
    end else if (m_p == 0) begin
      if (start) begin
        logic [32:0] r;
        r = ref_alu(alu_func, m_rd(src1), m_rd(src2), imm);
        m_z    <= r[31:0];
        m_zf_n <= (r[31:0] == 32'd0);
        m_cf_n <= r[32];
        if (dst != 4'd0) m_reg[dst] <= r[31:0];
        m_p <= 1;
      end
    end else begin
      if (m_p == 2) begin
        m_zf <= m_zf_n;
        m_cf <= m_cf_n;
      end
      m_p <= (m_p == 4 + NC) ? 0 : m_p + 1;
    end
  end

  // Per-cycle compare of every output of the 32-bit instance.
  always @(negedge clk) begin
    logic        e_val;
    logic [15:0] e_out;
    int          k;
    e_val = (m_p >= 4) && (m_p <= 3 + NC);
    k     = e_val ? m_p - 4 : 0;
    e_out = e_val ? m_z[16*k +: 16] : 16'd0;
    check("cyc_busy",  64'(busy),       64'(m_p != 0));
    check("cyc_done",  64'(done),       64'(m_p == 4 + NC));
    check("cyc_valid", 64'(out_valid),  64'(e_val));
    check("cyc_out",   64'(out),        64'(e_out));
    check("cyc_idx",   64'(chunk_idx),  64'(k));
    check("cyc_zf",    64'(zero_flag),  64'(m_zf));
    check("cyc_cf",    64'(carry_flag), 64'(m_cf));
  end

  // ---------------- directed stimulus helpers ----------------
  logic [15:0] s_out [6];
  logic        s_val [6];
  logic        s_done[6];
  logic        s_busy[6];
  logic        s_idx [6];

  // Issue one op; sample outputs in the cycles after edges E0..E5.
  task automatic do_op(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [31:0] iv);
    @(negedge clk);
    alu_func = f; src1 = a; src2 = b; dst = d; imm = iv; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        alu_func = 4'($urandom); src1 = 4'($urandom); src2 = 4'($urandom);
        dst = 4'($urandom); imm = $urandom;
      end
      s_out[k] = out; s_val[k] = out_valid; s_done[k] = done;
      s_busy[k] = busy; s_idx[k] = chunk_idx;
    end
  endtask

  logic [15:0] s64_out [8];
  logic        s64_val [8];
  logic        s64_done[8];
  logic        s64_busy[8];
  logic [1:0]  s64_idx [8];

  task automatic do_op64(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [63:0] iv);
    @(negedge clk);
    func64 = f; s1_64 = a; s2_64 = b; d_64 = d; imm64 = iv; start64 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start64 = 1'b0; func64 = 4'($urandom); imm64 = {$urandom, $urandom};
      end
      s64_out[k] = out64; s64_val[k] = valid64; s64_done[k] = done64;
      s64_busy[k] = busy64; s64_idx[k] = idx64;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, n_idle, n_busy;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_flags", 64'({zero_flag, carry_flag, out_valid, done}), 64'd0);
    rst_n = 1'b1;

    // LDI timing and chunk order
    do_op(4'd12, 4'd0, 4'd0, 4'd1, 32'h1234_5678);
    check("ldi_c0", 64'(s_out[3]), 64'h5678);
    check("ldi_v0", 64'(s_val[3]), 64'd1);
    check("ldi_i0", 64'(s_idx[3]), 64'd0);
    check("ldi_c1", 64'(s_out[4]), 64'h1234);
    check("ldi_i1", 64'(s_idx[4]), 64'd1);
    check("ldi_early", 64'(s_val[2]), 64'd0);
    check("ldi_done", 64'(s_done[5]), 64'd1);
    check("ldi_done_early", 64'(s_done[4]), 64'd0);
    n_busy = 0;
    for (int k = 0; k < 6; k++) if (s_busy[k]) n_busy++;
    check("ldi_busy_len", 64'(n_busy), 64'd6);
    @(negedge clk);
    check("ldi_idle_after", 64'(busy), 64'd0);

    // ADD wrap with carry, SUB borrow
    do_op(4'd12, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF);
    do_op(4'd12, 4'd0, 4'd0, 4'd2, 32'h0000_0001);
    do_op(4'd0, 4'd1, 4'd2, 4'd3, 32'd0);
    check("add_c0", 64'(s_out[3]), 64'h0000);
    check("add_c1", 64'(s_out[4]), 64'h0000);
    check("add_flags", 64'({zero_flag, carry_flag}), 64'd3);
    do_op(4'd1, 4'd2, 4'd1, 4'd4, 32'd0);
    check("sub_c0", 64'(s_out[3]), 64'h0002);
    check("sub_c1", 64'(s_out[4]), 64'h0000);
    check("sub_flags", 64'({zero_flag, carry_flag}), 64'd1);

    // R0 hardwired zero
    do_op(4'd12, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF);
    check("ldi_r0_show", 64'(s_out[3]), 64'hBEEF);
    do_op(4'd9, 4'd0, 4'd0, 4'd5, 32'd0);
    check("mov_r0", 64'({s_out[4], s_out[3]}), 64'd0);
    check("mov_r0_zf", 64'(zero_flag), 64'd1);
    do_op(4'd9, 4'd5, 4'd0, 4'd6, 32'd0);
    check("mov_r5", 64'({s_out[4], s_out[3]}), 64'd0);

    // compares and shifts
    do_op(4'd10, 4'd1, 4'd2, 4'd7, 32'd0);
    check("slt", 64'({s_out[4], s_out[3]}), 64'd1);
    do_op(4'd11, 4'd1, 4'd2, 4'd7, 32'd0);
    check("sltu", 64'({s_out[4], s_out[3]}), 64'd0);
    check("sltu_zf", 64'(zero_flag), 64'd1);
    do_op(4'd12, 4'd0, 4'd0, 4'd7, 32'h8000_0000);
    do_op(4'd12, 4'd0, 4'd0, 4'd8, 32'd4);
    do_op(4'd8, 4'd7, 4'd8, 4'd9, 32'd0);
    check("sra", 64'({s_out[4], s_out[3]}), 64'hF800_0000);
    do_op(4'd7, 4'd7, 4'd8, 4'd9, 32'd0);
    check("srl", 64'({s_out[4], s_out[3]}), 64'h0800_0000);
    do_op(4'd6, 4'd2, 4'd8, 4'd9, 32'd0);
    check("sll", 64'({s_out[4], s_out[3]}), 64'h0000_0010);
    do_op(4'd4, 4'd1, 4'd7, 4'd10, 32'd0);
    check("xor", 64'({s_out[4], s_out[3]}), 64'h7FFF_FFFF);
    do_op(4'd2, 4'd1, 4'd8, 4'd10, 32'd0);
    do_op(4'd3, 4'd7, 4'd2, 4'd10, 32'd0);
    do_op(4'd5, 4'd7, 4'd0, 4'd10, 32'd0);
    check("not", 64'({s_out[4], s_out[3]}), 64'h7FFF_FFFF);

    // reserved op yields zero and still writes back
    do_op(4'd14, 4'd1, 4'd2, 4'd3, 32'h5555_5555);
    check("rsv_zf", 64'(zero_flag), 64'd1);
    check("rsv_cf", 64'(carry_flag), 64'd0);
    do_op(4'd9, 4'd3, 4'd0, 4'd11, 32'd0);
    check("rsv_wb", 64'({s_out[4], s_out[3]}), 64'd0);

    // start held high: back-to-back ops with one idle cycle between
    @(negedge clk);
    alu_func = 4'd12; src1 = 4'd0; src2 = 4'd0; dst = 4'd11; imm = 32'hA5A5_0001;
    start = 1'b1;
    n_done = 0; n_idle = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (done) n_done++;
      if (!busy) n_idle++;
    end
    start = 1'b0;
    check("b2b_dones", 64'(n_done), 64'd2);
    check("b2b_idle", 64'(n_idle), 64'd1);
    @(negedge clk);

    // start pulses during SHOW and DONE are ignored
    @(negedge clk);
    alu_func = 4'd12; dst = 4'd12; imm = 32'h0BAD_F00D; start = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k == 3) || (k == 5);
      if (done) n_done++;
    end
    start = 1'b0;
    check("ignore_dones", 64'(n_done), 64'd1);

    // reset during the second SHOW chunk
    do_op(4'd12, 4'd0, 4'd0, 4'd13, 32'h1357_2468);
    @(negedge clk);
    alu_func = 4'd9; src1 = 4'd13; dst = 4'd14; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    check("pre_rst_chunk1", 64'(out), 64'h1357);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd9, 4'd13, 4'd0, 4'd14, 32'd0);
    check("post_rst_r13", 64'({s_out[4], s_out[3]}), 64'd0);
    check("post_rst_zf", 64'(zero_flag), 64'd1);
    do_op(4'd9, 4'd1, 4'd0, 4'd14, 32'd0);
    check("post_rst_r1", 64'({s_out[4], s_out[3]}), 64'd0);

    // 64-bit instance
    do_op64(4'd12, 3'd0, 3'd0, 3'd1, 64'h0123_4567_89AB_CDEF);
    check("w64_c0", 64'(s64_out[3]), 64'hCDEF);
    check("w64_c1", 64'(s64_out[4]), 64'h89AB);
    check("w64_c2", 64'(s64_out[5]), 64'h4567);
    check("w64_c3", 64'(s64_out[6]), 64'h0123);
    check("w64_idx", 64'({s64_idx[3], s64_idx[4], s64_idx[5], s64_idx[6]}), 64'h1B);
    check("w64_valid", 64'({s64_val[2], s64_val[3], s64_val[6], s64_val[7]}), 64'h6);
    check("w64_done", 64'({s64_done[6], s64_done[7]}), 64'h1);
    n_busy = 0;
    for (int k = 0; k < 8; k++) if (s64_busy[k]) n_busy++;
    check("w64_busy_len", 64'(n_busy), 64'd8);
    do_op64(4'd12, 3'd0, 3'd0, 3'd2, 64'h8000_0000_0000_0000);
    do_op64(4'd12, 3'd0, 3'd0, 3'd3, 64'd4);
    do_op64(4'd8, 3'd2, 3'd3, 3'd4, 64'd0);
    check("w64_sra", 64'({s64_out[6], s64_out[5], s64_out[4], s64_out[3]}),
          64'hF800_0000_0000_0000);
    check("w64_sra_zf", 64'(zf64), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
